// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI register-access slave.
package spi_pkg;

    localparam int unsigned SPI_ADDR_W  = 7;
    localparam int unsigned SPI_DATA_W  = 8;
    localparam int unsigned SPI_FRAME_W = 16;
    localparam int unsigned SPI_RW_BIT  = 15;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the last two synchronized samples.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one extra sample for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI slave (SCLK idle high, sample on rise, drive on fall) that decodes a
// R/W + address + data frame into single-cycle register-bus strobes.
module spi_slave_regif
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = SPI_ADDR_W,
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned FRAME_W     = SPI_FRAME_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_en_o,
    output logic              reg_rd_en_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              frame_err_o
);

    localparam int unsigned CMD_W   = FRAME_W - DATA_W;
    localparam int unsigned SHIFT_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned FLUSH   = SYNC_STAGES + 1;
    localparam int unsigned FL_W    = $clog2(FLUSH + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_mosi_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(sclk_i),
        .level_o(sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(csn_i),
        .level_o(csn_s),
        .rise_o (csn_rise),
        .fall_o (csn_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(mosi_i),
        .level_o(mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sclk_s;

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [SHIFT_W-2:0]  rx_shift_q, rx_shift_d;
    logic [SHIFT_W-1:0]  rx_next;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic                rw_q, rw_d;
    logic                miso_q, miso_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                rd_dly_q;
    logic                ferr_q, ferr_d;
    logic [FL_W-1:0]     flush_cnt_q;
    logic                armed_q;
    logic                sclk_ok, rise_ok, fall_ok, last_bit;

    // csn_rise lets the edge seen in the same clk as csn deassertion count.
    assign sclk_ok  = ~csn_s | csn_rise;
    assign rise_ok  = sclk_rise & sclk_ok;
    assign fall_ok  = sclk_fall & sclk_ok;
    assign rx_next  = {rx_shift_q, mosi_s};
    assign cnt_inc  = bit_cnt_q + CNT_W'(1);
    assign last_bit = rise_ok && (cnt_inc == CNT_W'(FRAME_W));

    // Frame FSM next-state, shift registers and strobe generation.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        miso_d     = miso_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        ferr_d     = 1'b0;

        if (rd_dly_q) begin
            tx_shift_d = reg_rdata_i;
        end

        unique case (state_q)
            StIdle: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (csn_fall && armed_q) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (csn_rise) begin
                    ferr_d  = 1'b1;
                    miso_d  = 1'b0;
                    state_d = StIdle;
                end else if (rise_ok) begin
                    rx_shift_d = rx_next[SHIFT_W-2:0];
                    bit_cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(CMD_W)) begin
                        rw_d    = rx_next[ADDR_W];
                        addr_d  = rx_next[ADDR_W-1:0];
                        rd_en_d = ~rx_next[ADDR_W];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (fall_ok && !rw_q) begin
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
                if (last_bit) begin
                    rx_shift_d = rx_next[SHIFT_W-2:0];
                    bit_cnt_d  = cnt_inc;
                    if (rw_q) begin
                        wdata_d = rx_next[DATA_W-1:0];
                        wr_en_d = 1'b1;
                    end
                    if (csn_rise) begin
                        miso_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                    end
                end else if (csn_rise) begin
                    ferr_d  = 1'b1;
                    miso_d  = 1'b0;
                    state_d = StIdle;
                end else if (rise_ok) begin
                    rx_shift_d = rx_next[SHIFT_W-2:0];
                    bit_cnt_d  = cnt_inc;
                end
            end
            StDone: begin
                if (csn_rise) begin
                    miso_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rw_q       <= 1'b0;
            miso_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_dly_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            miso_q     <= miso_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_dly_q   <= rd_en_q;
            ferr_q     <= ferr_d;
        end
    end

    // After reset the synchronizers hold fake idle values; only accept a csn
    // fall once real samples have flushed through and csn was seen high, so
    // a frame cut by reset is ignored until csn toggles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_cnt_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            if (flush_cnt_q != FL_W'(FLUSH)) begin
                flush_cnt_q <= flush_cnt_q + FL_W'(1);
            end else if (csn_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign miso_o      = miso_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_en_o = wr_en_q;
    assign reg_rd_en_o = rd_en_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: SPI master tasks, a one-clk-latency
// register-file read model and a strobe monitor.
module tb_spi_slave_regif;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sclk_i = 1'b1;
    logic       csn_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic [6:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_wr_en_o;
    logic       reg_rd_en_o;
    logic [7:0] reg_rdata_i = 8'h00;
    logic       frame_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    int         wr_cnt, rd_cnt, ferr_cnt, both_cnt;
    logic       miso_hi;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] rd_byte;

    spi_slave_regif dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sclk_i     (sclk_i),
        .csn_i      (csn_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_wr_en_o(reg_wr_en_o),
        .reg_rd_en_o(reg_rd_en_o),
        .reg_rdata_i(reg_rdata_i),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file read port: data appears the clk after reg_rd_en.
    always @(posedge clk_i) begin
        if (reg_rd_en_o) reg_rdata_i <= rd_val;
        else reg_rdata_i <= 8'h00;
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (reg_wr_en_o) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = reg_addr_o;
            wr_data = reg_wdata_o;
        end
        if (reg_rd_en_o) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = reg_addr_o;
        end
        if (reg_wr_en_o && reg_rd_en_o) both_cnt = both_cnt + 1;
        if (frame_err_o) ferr_cnt = ferr_cnt + 1;
        if (miso_o === 1'b1) miso_hi = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic clr();
        wr_cnt   = 0;
        rd_cnt   = 0;
        ferr_cnt = 0;
        miso_hi  = 1'b0;
        wr_addr  = 7'h00;
        wr_data  = 8'h00;
        rd_addr  = 7'h00;
    endtask

    // SPI master at SCLK = clk/10; captures MISO on rising edges 9..16.
    task automatic spi_frame(input logic [15:0] word, input int n_edges,
                             input bit csn_with_last, output logic [7:0] rx);
        rx = 8'h00;
        csn_i = 1'b0;
        wait_clk(5);
        for (int i = 0; i < n_edges; i++) begin
            sclk_i = 1'b0;
            mosi_i = (i < 16) ? word[15-i] : 1'b0;
            wait_clk(5);
            sclk_i = 1'b1;
            if (i >= 8 && i < 16) rx[15-i] = miso_o;
            if (csn_with_last && i == n_edges - 1) csn_i = 1'b1;
            wait_clk(5);
        end
        csn_i  = 1'b1;
        mosi_i = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        wait_clk(5);
        rst_i = 1'b0;
        wait_clk(1);
        n_checks++; if (miso_o !== 1'b0) $display("FAIL reset_miso got %b want 0", miso_o); else n_pass++;
        n_checks++; if (reg_addr_o !== 7'h00) $display("FAIL reset_addr got %h want 00", reg_addr_o); else n_pass++;
        n_checks++; if (reg_wdata_o !== 8'h00) $display("FAIL reset_wdata got %h want 00", reg_wdata_o); else n_pass++;
        n_checks++; if (reg_wr_en_o !== 1'b0) $display("FAIL reset_wr_en got %b want 0", reg_wr_en_o); else n_pass++;
        n_checks++; if (reg_rd_en_o !== 1'b0) $display("FAIL reset_rd_en got %b want 0", reg_rd_en_o); else n_pass++;
        n_checks++; if (frame_err_o !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err_o); else n_pass++;
        wait_clk(10);
    endtask

    task automatic test_write();
        clr();
        spi_frame(16'h85A5, 16, 1'b0, rd_byte);
        n_checks++; if (wr_cnt != 1) $display("FAIL wr_count got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr !== 7'h05) $display("FAIL wr_addr got %h want 05", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'hA5) $display("FAIL wr_data got %h want a5", wr_data); else n_pass++;
        n_checks++; if (miso_hi !== 1'b0) $display("FAIL wr_miso_low got %b want 0", miso_hi); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL wr_ferr got %0d want 0", ferr_cnt); else n_pass++;
        n_checks++; if (rd_cnt != 0) $display("FAIL wr_no_rd got %0d want 0", rd_cnt); else n_pass++;
        n_checks++; if (reg_addr_o !== 7'h05) $display("FAIL wr_addr_hold got %h want 05", reg_addr_o); else n_pass++;
    endtask

    task automatic test_read();
        clr();
        rd_val = 8'h3C;
        spi_frame(16'h1200, 16, 1'b0, rd_byte);
        n_checks++; if (rd_cnt != 1) $display("FAIL rd_count got %0d want 1", rd_cnt); else n_pass++;
        n_checks++; if (rd_addr !== 7'h12) $display("FAIL rd_addr got %h want 12", rd_addr); else n_pass++;
        n_checks++; if (rd_byte !== 8'h3C) $display("FAIL rd_miso_data got %h want 3c", rd_byte); else n_pass++;
        n_checks++; if (wr_cnt != 0) $display("FAIL rd_no_wr got %0d want 0", wr_cnt); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL rd_ferr got %0d want 0", ferr_cnt); else n_pass++;
        n_checks++; if (miso_o !== 1'b0) $display("FAIL rd_miso_idle got %b want 0", miso_o); else n_pass++;
    endtask

    task automatic test_abort();
        clr();
        spi_frame(16'hFF55, 11, 1'b0, rd_byte);
        n_checks++; if (ferr_cnt != 1) $display("FAIL abort_ferr got %0d want 1", ferr_cnt); else n_pass++;
        n_checks++; if (wr_cnt != 0) $display("FAIL abort_no_wr got %0d want 0", wr_cnt); else n_pass++;
        n_checks++; if (rd_cnt != 0) $display("FAIL abort_no_rd got %0d want 0", rd_cnt); else n_pass++;
        clr();
        spi_frame(16'h8001, 16, 1'b0, rd_byte);
        n_checks++; if (wr_cnt != 1) $display("FAIL abort_next_wr got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr !== 7'h00) $display("FAIL abort_next_addr got %h want 00", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'h01) $display("FAIL abort_next_data got %h want 01", wr_data); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL abort_next_ferr got %0d want 0", ferr_cnt); else n_pass++;
    endtask

    task automatic test_extra_clocks();
        clr();
        spi_frame(16'h8A0F, 18, 1'b0, rd_byte);
        n_checks++; if (wr_cnt != 1) $display("FAIL extra_wr got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr !== 7'h0A) $display("FAIL extra_addr got %h want 0a", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'h0F) $display("FAIL extra_data got %h want 0f", wr_data); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL extra_ferr got %0d want 0", ferr_cnt); else n_pass++;
        n_checks++; if (reg_wdata_o !== 8'h0F) $display("FAIL extra_wdata_hold got %h want 0f", reg_wdata_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clr();
        rd_val = 8'hC3;
        spi_frame(16'h7F00, 16, 1'b0, rd_byte);
        wait_clk(10);
        spi_frame(16'hFFFF, 16, 1'b0, rd_byte);
        n_checks++; if (rd_cnt != 1) $display("FAIL b2b_rd_count got %0d want 1", rd_cnt); else n_pass++;
        n_checks++; if (rd_addr !== 7'h7F) $display("FAIL b2b_rd_addr got %h want 7f", rd_addr); else n_pass++;
        n_checks++; if (wr_cnt != 1) $display("FAIL b2b_wr_count got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr !== 7'h7F) $display("FAIL b2b_wr_addr got %h want 7f", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'hFF) $display("FAIL b2b_wr_data got %h want ff", wr_data); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL b2b_ferr got %0d want 0", ferr_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back_read_data();
        // Separate read so its captured byte is not overwritten by the write.
        clr();
        rd_val = 8'hC3;
        spi_frame(16'h7F00, 16, 1'b0, rd_byte);
        n_checks++; if (rd_byte !== 8'hC3) $display("FAIL b2b_rd_data got %h want c3", rd_byte); else n_pass++;
    endtask

    task automatic test_simultaneous();
        clr();
        spi_frame(16'h8C5A, 16, 1'b1, rd_byte);
        n_checks++; if (wr_cnt != 1) $display("FAIL simul_wr got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_data !== 8'h5A) $display("FAIL simul_data got %h want 5a", wr_data); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL simul_ferr got %0d want 0", ferr_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] word;
        word = 16'h8133;
        clr();
        csn_i = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 16; i++) begin
            sclk_i = 1'b0;
            mosi_i = word[15-i];
            wait_clk(5);
            sclk_i = 1'b1;
            if (i == 5) begin
                rst_i = 1'b1;
                wait_clk(1);
                rst_i = 1'b0;
                n_checks++; if (reg_addr_o !== 7'h00) $display("FAIL rstmid_addr got %h want 00", reg_addr_o); else n_pass++;
                n_checks++; if (reg_wdata_o !== 8'h00) $display("FAIL rstmid_wdata got %h want 00", reg_wdata_o); else n_pass++;
                n_checks++; if (miso_o !== 1'b0) $display("FAIL rstmid_miso got %b want 0", miso_o); else n_pass++;
                n_checks++; if (frame_err_o !== 1'b0) $display("FAIL rstmid_ferr_now got %b want 0", frame_err_o); else n_pass++;
                wait_clk(4);
            end else begin
                wait_clk(5);
            end
        end
        csn_i  = 1'b1;
        mosi_i = 1'b0;
        wait_clk(20);
        n_checks++; if (wr_cnt != 0) $display("FAIL rstmid_no_wr got %0d want 0", wr_cnt); else n_pass++;
        n_checks++; if (rd_cnt != 0) $display("FAIL rstmid_no_rd got %0d want 0", rd_cnt); else n_pass++;
        n_checks++; if (ferr_cnt != 0) $display("FAIL rstmid_no_ferr got %0d want 0", ferr_cnt); else n_pass++;
        clr();
        spi_frame(16'h8133, 16, 1'b0, rd_byte);
        n_checks++; if (wr_cnt != 1) $display("FAIL rstmid_next_wr got %0d want 1", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr !== 7'h01) $display("FAIL rstmid_next_addr got %h want 01", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'h33) $display("FAIL rstmid_next_data got %h want 33", wr_data); else n_pass++;
    endtask

    initial begin
        both_cnt = 0;
        clr();
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_extra_clocks();
        test_back_to_back();
        test_back_to_back_read_data();
        test_simultaneous();
        test_reset_mid_frame();
        n_checks++; if (both_cnt != 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
